// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide: one shift-add or restoring-divide step per cycle,
// with sign and exception fix-up applied as the result is registered on leaving DONE.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic               neg, op_div, div_exc;

  logic               start;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_r, div_diff;
  logic [2*WIDTH-1:0] mul_nx, div_nx, prod;
  logic [WIDTH-1:0]   quo;
  logic               mul_ovf;

  assign start = ctrl_MULT | ctrl_DIV;
  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  assign div_r    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_r - {1'b0, mcand};
  assign div_nx   = (div_r >= {1'b0, mcand}) ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                                             : {div_r[WIDTH-1:0],    acc[WIDTH-2:0], 1'b0};

  assign prod    = neg ? -acc : acc;
  assign mul_ovf = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
  assign quo     = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      MUL, DIV: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = state;
    endcase
    if (ctrl_MULT)     state_nx = MUL;
    else if (ctrl_DIV) state_nx = DIV;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      mcand   <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      op_div  <= 1'b0;
      div_exc <= 1'b0;
    end else if (start) begin
      cnt     <= '0;
      mcand   <= b_mag;
      acc     <= {{WIDTH{1'b0}}, a_mag};
      neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      op_div  <= ~ctrl_MULT;
      div_exc <= (data_operandB == '0) ||
                 (data_operandA == MIN_NEG && data_operandB == '1);
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      acc <= op_div ? div_nx : mul_nx;
    end
  end

  // A start arriving during DONE aborts that op, so it never reports.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= (state == DONE) && !start;
      if (state == DONE && !start) begin
        if (op_div) begin
          data_exception <= div_exc;
          data_result    <= div_exc ? '0 : quo;
        end else begin
          data_exception <= mul_ovf;
          data_result    <= mul_ovf ? '0 : prod[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, busy length, signed results,
// exception cases, abort-by-restart and asynchronous reset mid-operation.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .ctrl_MULT(ctrl_MULT),
    .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA),
    .data_operandB(data_operandB),
    .data_result(data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge; drives a start sampled at the next edge.
  task automatic start_op(input logic is_mul, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = is_mul;
    ctrl_DIV      = ~is_mul;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // k = 0 is just after the start edge; k = n is just after the n-th following edge.
  task automatic watch(input int ncyc, output int first_rdy, output int rdy_cnt,
                       output int busy_cnt, output logic [31:0] res, output logic exc);
    first_rdy = -1;
    rdy_cnt   = 0;
    busy_cnt  = 0;
    res       = '0;
    exc       = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if (k > 0) begin
        @(posedge clock);
        #1;
      end
      if (busy) busy_cnt++;
      if (data_resultRDY) begin
        rdy_cnt++;
        if (first_rdy < 0) begin
          first_rdy = k;
          res       = data_result;
          exc       = data_exception;
        end
      end
    end
  endtask

  task automatic run_op(input string tag, input logic is_mul, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_exc);
    int fr, rc, bc;
    logic [31:0] r;
    logic e;
    start_op(is_mul, a, b);
    watch(37, fr, rc, bc, r, e);
    check({tag, " rdy_at"}, fr, 33);
    check({tag, " rdy_cnt"}, rc, 1);
    check({tag, " busy_cycles"}, bc, 32);
    check({tag, " result"}, r, exp_res);
    check({tag, " exception"}, e, exp_exc);
  endtask

  initial begin
    int fr, rc, bc, stray;
    logic [31:0] r;
    logic e;

    #12;
    check("reset result", data_result, 0);
    check("reset exception", data_exception, 0);
    check("reset rdy", data_resultRDY, 0);
    check("reset busy", busy, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    run_op("mul 3*-4", 1'b1, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF4, 1'b0);
    run_op("mul ovf", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1);
    run_op("mul min*1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
    run_op("div -7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("div 100/-10", 1'b0, 32'd100, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0);
    run_op("div 5/0", 1'b0, 32'd5, 32'd0, 32'h0, 1'b1);
    run_op("div min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    run_op("mul -5*-6", 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30, 1'b0);

    repeat (3) @(posedge clock);
    #1;
    check("hold result", data_result, 32'd30);
    check("hold rdy low", data_resultRDY, 0);

    // Restart: a DIV issued mid-MULT replaces it; only the DIV reports.
    start_op(1'b1, 32'd6, 32'd7);
    stray = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) stray++;
    end
    check("abort mid-mul rdy", stray, 0);
    run_op("abort div 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 1'b0);

    // Asynchronous reset in the middle of a multiply.
    start_op(1'b1, 32'h0001_2345, 32'h10);
    repeat (15) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset rdy", data_resultRDY, 0);
    check("midreset result", data_result, 0);
    check("midreset exception", data_exception, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    watch(40, fr, rc, bc, r, e);
    check("post-reset no rdy", rc, 0);
    check("post-reset no busy", bc, 0);
    run_op("mul 2*2", 1'b1, 32'd2, 32'd2, 32'd4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage, directly downstream of the instruction control decoder.
- The decoder issues a one-cycle start pulse when it sees an R-type instruction (opcode 00000) with ALU func mul (00110) or div (00111).
- The pipeline stalls while busy is high.
- On completion the unit returns the result and an exception flag. The decoder/writeback path uses the flag to write rstatus (mul = 4, div = 5).

Parameters:
- WIDTH, 32, operand and result width; the iteration count equals WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- ctrl_MULT  input  1  start-multiply pulse, sampled at the rising edge
- ctrl_DIV  input  1  start-divide pulse, sampled at the rising edge
- data_operandA  input  WIDTH  multiplicand / dividend, two's complement
- data_operandB  input  WIDTH  multiplier / divisor, two's complement
- data_result  output  WIDTH  product (low WIDTH bits) or quotient
- data_exception  output  1  overflow or divide-by-zero; valid while data_resultRDY = 1
- data_resultRDY  output  1  one-cycle completion pulse
- busy  output  1  high while an operation is in progress

Behaviour:
- Reset (reset = 0, asynchronous):
  - state goes to IDLE; counter, accumulators and latched operands clear to 0.
  - data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0.
  - An operation in progress is discarded and never signals RDY.
- State machine: IDLE, MUL, DIV, DONE.
- Start:
  - At edge T with ctrl_MULT = 1, latch operandA/B and the op type, clear counter to 0, enter MUL. ctrl_DIV enters DIV the same way.
  - busy = 1 from the cycle after T.
  - If both ctrl_MULT and ctrl_DIV are 1, MULT wins.
- MUL: shift-add on operand magnitudes, one bit per cycle, 2*WIDTH-bit accumulator. The result sign is the XOR of the operand signs; negate the full 2*WIDTH-bit product at the end.
- DIV: restoring division on magnitudes, one quotient bit per cycle. The quotient truncates toward zero (sign = XOR of operand signs). The remainder is discarded.
- Counter: increments each cycle in MUL/DIV. When it reaches WIDTH-1, the next state is DONE.
- DONE lasts one cycle:
  - data_resultRDY = 1, busy = 0, data_result and data_exception updated.
  - Next state is IDLE, or MUL/DIV directly if a start pulse arrives in this cycle.
- Latency: start sampled at edge T, so data_resultRDY is high during the cycle after edge T+WIDTH+1, i.e. 33 cycles after the start edge for WIDTH = 32. Latency does not depend on data.
- Multiply exception: set when the full 64-bit signed product differs from the sign extension of its low 32 bits. In that case data_result = 0 and data_exception = 1. Otherwise data_result = low 32 bits.
- Divide exception:
  - Divisor = 0: data_result = 0, data_exception = 1. The full iteration count is still used.
  - Dividend = 0x80000000 with divisor = 0xFFFFFFFF: data_result = 0, data_exception = 1.
- Start while busy (MUL, DIV or DONE): the new op aborts the current one and restarts with new operands and op type. The aborted op never asserts RDY.
- Operand inputs are ignored except at a start edge; they may change freely while busy.
- Output hold: data_result and data_exception hold their values after DONE until the next DONE or reset. data_resultRDY is exactly one cycle wide.
- Start pulse held high for multiple cycles: each high edge restarts, so the op completes WIDTH+1 cycles after the last high edge.

Test Plan:
- Reset, then ctrl_MULT pulse with A = 3, B = -4 (0xFFFFFFFC) -> busy high 32 cycles; data_resultRDY pulses once, 33 cycles after the start edge; data_result = 0xFFFFFFF4, data_exception = 0.
- MULT A = 0x00010000, B = 0x00010000 -> data_result = 0, data_exception = 1. MULT A = 0x80000000, B = 1 -> data_result = 0x80000000, data_exception = 0.
- DIV A = -7, B = 2 -> data_result = 0xFFFFFFFD (-3), data_exception = 0. DIV A = 100, B = -10 -> data_result = 0xFFFFFFF6.
- DIV A = 5, B = 0 -> data_result = 0, data_exception = 1 at the normal latency. DIV A = 0x80000000, B = 0xFFFFFFFF -> data_result = 0, data_exception = 1.
- Start MULT 6*7; 10 cycles later start DIV 9/3 -> exactly one RDY pulse, 33 cycles after the DIV start edge, with data_result = 3. No RDY for the MULT.
- Reset asserted at cycle 15 of a MULT -> all outputs 0 immediately. No RDY after reset releases. A new MULT 2*2 then returns 4 normally.
